// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - states, opcodes, funct3 codes and access-size helper for mem_access_mc
package mem_access_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_e;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_D
    } size_e;

    // Low two funct3 bits select the width for both loads and stores.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        size_e sz;
        sz = size_e'(funct3[1:0]);
        case (sz)
            SZ_B:    return 4'd1;
            SZ_H:    return 4'd2;
            SZ_W:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_dmem.sv
// rtl/mem_access_dmem.sv - byte data memory with 8-byte read port and byte-enable write port
module mem_access_dmem #(
    parameter  int DMEM_BYTES = 256,
    localparam int AW         = $clog2(DMEM_BYTES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    output logic [63:0]   rdata,
    input  logic          we,
    input  logic [7:0]    wbe,
    input  logic [63:0]   wdata
);

    logic [7:0] mem_q [DMEM_BYTES];
    logic [7:0] mem_d [DMEM_BYTES];

    // Byte lanes start at addr, so misaligned accesses need no extra shifting.
    for (genvar g = 0; g < 8; g++) begin : g_rd
        assign rdata[8*g +: 8] = mem_q[addr + AW'(g)];
    end

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (wbe[i]) begin
                    mem_d[addr + AW'(i)] = wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DMEM_BYTES; i++) begin
                mem_q[i] <= 8'(i);
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/mem_access_mc.sv
// rtl/mem_access_mc.sv - multi-cycle RISC-V load/store datapath; MEMACCESS_MISALIGN_EN permits misaligned access
module mem_access_mc
    import mem_access_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int NREGS      = 32,
    parameter int DMEM_BYTES = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic            instr_valid,
    output logic            instr_ready,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            fault,
    output logic            busy
);

    localparam int AW = $clog2(DMEM_BYTES);

    state_e          state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] rs1v_q, rs1v_d, rs2v_q, rs2v_d;
    logic [XLEN-1:0] imm_q, imm_d, ea_q, ea_d;
    logic [XLEN-1:0] mres_q, mres_d, result_q, result_d;
    logic            mflt_q, mflt_d, rvalid_q, rvalid_d, fault_q, fault_d;
    logic [XLEN-1:0] x_q [NREGS];
    logic [XLEN-1:0] x_d [NREGS];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [11:0] imm12;
    logic        is_load, is_store, illegal, out_of_range, mem_fault;
    logic [3:0]  size;
    logic [63:0] rdata, wdata, ld_ext;
    logic [7:0]  wbe;
    logic        dmem_we;

    assign opcode   = instr_q[6:0];
    assign rd       = instr_q[11:7];
    assign funct3   = instr_q[14:12];
    assign rs1      = instr_q[19:15];
    assign rs2      = instr_q[24:20];
    assign is_load  = (opcode == OPC_LOAD);
    assign is_store = (opcode == OPC_STORE);
    assign imm12    = is_store ? {instr_q[31:25], instr_q[11:7]} : instr_q[31:20];
    assign size     = size_bytes(funct3);

    always_comb begin
        illegal = 1'b1;
        if (is_load) begin
            illegal = (funct3 == 3'b111) || ((XLEN == 32) && (funct3 == F3_D || funct3 == F3_WU));
        end else if (is_store) begin
            illegal = funct3[2] || ((XLEN == 32) && (funct3 == F3_D));
        end
    end

    // Written as "EA > limit" so that EA near 2^XLEN cannot wrap past the check.
    assign out_of_range = ea_q > (XLEN'(DMEM_BYTES) - XLEN'(size));

`ifdef MEMACCESS_MISALIGN_EN
    assign mem_fault = illegal || out_of_range;
`else
    logic misalign;
    assign misalign  = (ea_q[2:0] & 3'(size - 4'd1)) != 3'd0;
    assign mem_fault = illegal || out_of_range || misalign;
`endif

    always_comb begin
        case (funct3)
            F3_B:    ld_ext = {{56{rdata[7]}}, rdata[7:0]};
            F3_H:    ld_ext = {{48{rdata[15]}}, rdata[15:0]};
            F3_W:    ld_ext = {{32{rdata[31]}}, rdata[31:0]};
            F3_BU:   ld_ext = {56'd0, rdata[7:0]};
            F3_HU:   ld_ext = {48'd0, rdata[15:0]};
            F3_WU:   ld_ext = {32'd0, rdata[31:0]};
            default: ld_ext = rdata;
        endcase
    end

    always_comb begin
        case (size)
            4'd1:    wbe = 8'h01;
            4'd2:    wbe = 8'h03;
            4'd4:    wbe = 8'h0F;
            default: wbe = 8'hFF;
        endcase
    end

    assign wdata   = 64'(rs2v_q);
    assign dmem_we = (state_q == ST_MEM) && is_store && !mem_fault;

    mem_access_dmem #(.DMEM_BYTES(DMEM_BYTES)) u_dmem (
        .clk   (clk),
        .rst   (rst),
        .addr  (ea_q[AW-1:0]),
        .rdata (rdata),
        .we    (dmem_we),
        .wbe   (wbe),
        .wdata (wdata)
    );

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        rs1v_d   = rs1v_q;
        rs2v_d   = rs2v_q;
        imm_d    = imm_q;
        ea_d     = ea_q;
        mres_d   = mres_q;
        mflt_d   = mflt_q;
        result_d = result_q;
        rvalid_d = 1'b0;
        fault_d  = 1'b0;
        x_d      = x_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                rs1v_d  = x_q[rs1];
                rs2v_d  = x_q[rs2];
                imm_d   = {{(XLEN-12){imm12[11]}}, imm12};
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                ea_d    = rs1v_q + imm_q;
                state_d = ST_MEM;
            end
            ST_MEM: begin
                mflt_d  = mem_fault;
                mres_d  = (is_load && !mem_fault) ? ld_ext[XLEN-1:0] : ea_q;
                state_d = ST_WB;
            end
            ST_WB: begin
                result_d = mres_q;
                rvalid_d = 1'b1;
                fault_d  = mflt_q;
                // x0 is never written, so its reset value of zero holds forever.
                if (is_load && !mflt_q && rd != 5'd0) begin
                    x_d[rd] = mres_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            instr_q  <= '0;
            rs1v_q   <= '0;
            rs2v_q   <= '0;
            imm_q    <= '0;
            ea_q     <= '0;
            mres_q   <= '0;
            mflt_q   <= 1'b0;
            result_q <= '0;
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                x_q[i] <= XLEN'(i);
            end
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            rs1v_q   <= rs1v_d;
            rs2v_q   <= rs2v_d;
            imm_q    <= imm_d;
            ea_q     <= ea_d;
            mres_q   <= mres_d;
            mflt_q   <= mflt_d;
            result_q <= result_d;
            rvalid_q <= rvalid_d;
            fault_q  <= fault_d;
            x_q      <= x_d;
        end
    end

    assign instr_ready  = (state_q == ST_IDLE);
    assign busy         = !instr_ready;
    assign result       = result_q;
    assign result_valid = rvalid_q;
    assign fault        = fault_q;

endmodule
